// File: rtl/tff_bank_ctrl.sv
// Command sequencer for a bank of W synchronous T flip-flops: turns queued
// count-up/down, load and clear commands into per-bit toggle enables.
module tff_bank_ctrl #(
    parameter int W     = 4,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [1:0]       cmd_op,
    input  logic [CNT_W-1:0] cmd_arg,
    input  logic             halt,
    input  logic [W-1:0]     q_in,
    output logic [W-1:0]     t_out,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] remaining
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_DONE
    } state_t;

    typedef enum logic [1:0] {
        OP_UP    = 2'b00,
        OP_DOWN  = 2'b01,
        OP_LOAD  = 2'b10,
        OP_CLEAR = 2'b11
    } op_t;

    state_t           state_q, state_d;
    op_t              op_q, op_d;
    logic [W-1:0]     arg_q, arg_d;
    logic [CNT_W-1:0] rem_q, rem_d;

    logic [W-1:0] up_t, down_t, step_t;

    // Ripple-carry/borrow toggle pattern: bit i flips when all lower bits are 1 (up) or 0 (down).
    always_comb begin
        logic up_acc;
        logic dn_acc;
        up_acc = 1'b1;
        dn_acc = 1'b1;
        up_t   = '0;
        down_t = '0;
        for (int i = 0; i < W; i++) begin
            up_t[i]   = up_acc;
            down_t[i] = dn_acc;
            up_acc    = up_acc & q_in[i];
            dn_acc    = dn_acc & ~q_in[i];
        end
    end

    always_comb begin
        step_t = '0;
        case (op_q)
            OP_UP:    step_t = up_t;
            OP_DOWN:  step_t = down_t;
            OP_LOAD:  step_t = q_in ^ arg_q;
            OP_CLEAR: step_t = q_in;
            default:  step_t = '0;
        endcase
    end

    always_comb begin
        state_d   = state_q;
        op_d      = op_q;
        arg_d     = arg_q;
        rem_d     = rem_q;
        t_out     = '0;
        cmd_ready = 1'b0;
        busy      = 1'b0;
        done      = 1'b0;
        case (state_q)
            ST_IDLE: begin
                cmd_ready = 1'b1;
                if (cmd_valid) begin
                    op_d  = op_t'(cmd_op);
                    arg_d = cmd_arg[W-1:0];
                    if (cmd_op[1]) begin
                        state_d = ST_RUN;
                        rem_d   = CNT_W'(1);
                    end else if (cmd_arg == '0) begin
                        state_d = ST_DONE;
                        rem_d   = '0;
                    end else begin
                        state_d = ST_RUN;
                        rem_d   = cmd_arg;
                    end
                end
            end
            ST_RUN: begin
                busy = 1'b1;
                if (!halt) begin
                    // Gate toggles during reset so an aborted command leaves the bank untouched.
                    t_out = rst ? step_t : '0;
                    rem_d = rem_q - CNT_W'(1);
                    if (rem_q == CNT_W'(1)) begin
                        state_d = ST_DONE;
                    end
                end
            end
            ST_DONE: begin
                done    = 1'b1;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            op_q    <= OP_UP;
            arg_q   <= '0;
            rem_q   <= '0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            arg_q   <= arg_d;
            rem_q   <= rem_d;
        end
    end

    assign remaining = rem_q;

endmodule

// File: tb/tb_tff_bank_ctrl.sv
// Self-checking bench: drives tff_bank_ctrl against a small T flip-flop bank
// and scoreboards every expected bank value in the order steps occur.
module tb_tff_bank_ctrl;

    localparam int W     = 4;
    localparam int CNT_W = 8;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic             bank_rst = 1'b1;
    logic             cmd_valid = 1'b0;
    logic             cmd_ready;
    logic [1:0]       cmd_op = 2'b00;
    logic [CNT_W-1:0] cmd_arg = '0;
    logic             halt = 1'b0;
    logic [W-1:0]     q_in;
    logic [W-1:0]     t_out;
    logic             busy;
    logic             done;
    logic [CNT_W-1:0] remaining;

    int checks = 0;
    int errors = 0;
    logic [W-1:0] exp_q[$];
    logic step_pending = 1'b0;

    localparam logic [1:0] OP_UP    = 2'b00;
    localparam logic [1:0] OP_DOWN  = 2'b01;
    localparam logic [1:0] OP_LOAD  = 2'b10;
    localparam logic [1:0] OP_CLEAR = 2'b11;

    always #5 clk = ~clk;

    tff_bank_ctrl #(.W(W), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_op(cmd_op), .cmd_arg(cmd_arg), .halt(halt), .q_in(q_in),
        .t_out(t_out), .busy(busy), .done(done), .remaining(remaining)
    );

    for (genvar g = 0; g < W; g++) begin : g_tff
        logic q_r;
        always @(posedge clk) begin
            if (bank_rst) q_r <= 1'b0;
            else if (t_out[g]) q_r <= ~q_r;
        end
        assign q_in[g] = q_r;
    end

    // Each non-halted RUN cycle seen at one falling edge must show its result at the next.
    always @(negedge clk) begin
        if (step_pending) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL scoreboard_unexpected_step q=%h (no step expected)", q_in);
            end else begin
                logic [W-1:0] e;
                e = exp_q.pop_front();
                if (q_in !== e) begin
                    errors++;
                    $display("FAIL scoreboard_q got=%h expected=%h", q_in, e);
                end
            end
        end
        step_pending = (busy === 1'b1) && (halt === 1'b0) && (rst === 1'b1);
    end

    task automatic issue(input logic [1:0] op, input logic [CNT_W-1:0] arg);
        int waited = 0;
        cmd_op = op;
        cmd_arg = arg;
        cmd_valid = 1'b1;
        while (cmd_ready !== 1'b1 && waited < 50) begin
            @(posedge clk); #1;
            waited++;
        end
        checks++;
        if (cmd_ready !== 1'b1) begin
            errors++;
            $display("FAIL accept_timeout cmd_ready=%b expected=1", cmd_ready);
        end
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        cmd_op = ~op;
        cmd_arg = ~arg;
    endtask

    task automatic wait_done(input int budget, output bit seen, output int edges, output int busy_cyc);
        seen = 1'b0;
        edges = 0;
        busy_cyc = 0;
        while (!seen && edges < budget) begin
            if (busy === 1'b1) busy_cyc++;
            @(posedge clk); #1;
            edges++;
            if (done === 1'b1) seen = 1'b1;
        end
    endtask

    task automatic test_reset();
        rst = 1'b0;
        bank_rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({cmd_ready, busy, done} !== 3'b100 || remaining !== '0 || t_out !== '0) begin
            errors++;
            $display("FAIL reset_state rdy/busy/done=%b rem=%0d t=%h expected 100/0/0",
                     {cmd_ready, busy, done}, remaining, t_out);
        end
        rst = 1'b1;
        bank_rst = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_clear_count_up();
        bit seen;
        int edges, bc;
        exp_q.push_back(4'h0);
        issue(OP_CLEAR, 8'h00);
        wait_done(10, seen, edges, bc);
        checks++;
        if (!seen || edges != 1) begin
            errors++;
            $display("FAIL clear_latency seen=%b edges=%0d expected 1 1", seen, edges);
        end
        @(posedge clk); #1;
        for (int v = 1; v <= 5; v++) exp_q.push_back(W'(v));
        issue(OP_UP, 8'd5);
        for (int k = 5; k >= 1; k--) begin
            checks++;
            if (busy !== 1'b1 || remaining !== CNT_W'(k)) begin
                errors++;
                $display("FAIL up5_remaining busy=%b rem=%0d expected 1 %0d", busy, remaining, k);
            end
            @(posedge clk); #1;
        end
        checks++;
        if (done !== 1'b1 || busy !== 1'b0 || remaining !== '0 || q_in !== 4'h5) begin
            errors++;
            $display("FAIL up5_done done=%b busy=%b rem=%0d q=%h expected 1 0 0 5",
                     done, busy, remaining, q_in);
        end
        @(posedge clk); #1;
        checks++;
        if (done !== 1'b0 || cmd_ready !== 1'b1) begin
            errors++;
            $display("FAIL up5_single_pulse done=%b ready=%b expected 0 1", done, cmd_ready);
        end
    endtask

    task automatic test_load();
        exp_q.push_back(4'hE);
        issue(OP_LOAD, 8'h0E);
        checks++;
        if (t_out !== 4'hB || busy !== 1'b1 || remaining !== CNT_W'(1)) begin
            errors++;
            $display("FAIL load_toggle t=%h busy=%b rem=%0d expected b 1 1", t_out, busy, remaining);
        end
        @(posedge clk); #1;
        checks++;
        if (done !== 1'b1 || t_out !== '0 || q_in !== 4'hE) begin
            errors++;
            $display("FAIL load_done done=%b t=%h q=%h expected 1 0 e", done, t_out, q_in);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_wrap();
        bit seen;
        int edges, bc;
        exp_q.push_back(4'hF);
        issue(OP_LOAD, 8'h0F);
        wait_done(10, seen, edges, bc);
        @(posedge clk); #1;
        exp_q.push_back(4'h0); exp_q.push_back(4'h1); exp_q.push_back(4'h2);
        issue(OP_UP, 8'd3);
        wait_done(20, seen, edges, bc);
        checks++;
        if (!seen || edges != 3 || q_in !== 4'h2) begin
            errors++;
            $display("FAIL wrap_up seen=%b edges=%0d q=%h expected 1 3 2", seen, edges, q_in);
        end
        @(posedge clk); #1;
        exp_q.push_back(4'h1); exp_q.push_back(4'h0); exp_q.push_back(4'hF); exp_q.push_back(4'hE);
        issue(OP_DOWN, 8'd4);
        wait_done(20, seen, edges, bc);
        checks++;
        if (!seen || edges != 4 || q_in !== 4'hE) begin
            errors++;
            $display("FAIL wrap_down seen=%b edges=%0d q=%h expected 1 4 e", seen, edges, q_in);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_halt();
        bit seen;
        int edges, bc;
        exp_q.push_back(4'h0);
        issue(OP_CLEAR, 8'h00);
        wait_done(10, seen, edges, bc);
        @(posedge clk); #1;
        for (int v = 1; v <= 6; v++) exp_q.push_back(W'(v));
        issue(OP_UP, 8'd6);
        repeat (2) begin @(posedge clk); #1; end
        halt = 1'b1;
        for (int k = 0; k < 3; k++) begin
            #1;
            checks++;
            if (t_out !== '0 || remaining !== CNT_W'(4) || q_in !== 4'h2) begin
                errors++;
                $display("FAIL halt_hold t=%h rem=%0d q=%h expected 0 4 2", t_out, remaining, q_in);
            end
            @(posedge clk); #1;
        end
        halt = 1'b0;
        wait_done(20, seen, edges, bc);
        checks++;
        if (!seen || q_in !== 4'h6 || (bc + 5) != 9) begin
            errors++;
            $display("FAIL halt_total seen=%b q=%h busy_cycles=%0d expected 1 6 9", seen, q_in, bc + 5);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_back_to_back();
        bit seen;
        int edges, bc;
        issue(OP_UP, 8'd0);
        checks++;
        if (done !== 1'b1 || busy !== 1'b0 || t_out !== '0) begin
            errors++;
            $display("FAIL zero_count done=%b busy=%b t=%h expected 1 0 0", done, busy, t_out);
        end
        @(posedge clk); #1;
        checks++;
        if (done !== 1'b0 || q_in !== 4'h6) begin
            errors++;
            $display("FAIL zero_count_after done=%b q=%h expected 0 6", done, q_in);
        end
        exp_q.push_back(4'h7); exp_q.push_back(4'h8); exp_q.push_back(4'h7);
        issue(OP_UP, 8'd2);
        cmd_op = OP_DOWN;
        cmd_arg = 8'd1;
        cmd_valid = 1'b1;
        for (int k = 0; k < 3; k++) begin
            checks++;
            if (cmd_ready !== 1'b0) begin
                errors++;
                $display("FAIL backpressure cycle=%0d ready=%b expected 0", k, cmd_ready);
            end
            @(posedge clk); #1;
        end
        checks++;
        if (cmd_ready !== 1'b1) begin
            errors++;
            $display("FAIL b2b_ready ready=%b expected 1", cmd_ready);
        end
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        checks++;
        if (busy !== 1'b1 || remaining !== CNT_W'(1)) begin
            errors++;
            $display("FAIL b2b_accept busy=%b rem=%0d expected 1 1", busy, remaining);
        end
        wait_done(10, seen, edges, bc);
        checks++;
        if (!seen || q_in !== 4'h7) begin
            errors++;
            $display("FAIL b2b_final seen=%b q=%h expected 1 7", seen, q_in);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_abort();
        bit seen;
        int edges, bc;
        exp_q.push_back(4'h0);
        issue(OP_CLEAR, 8'h00);
        wait_done(10, seen, edges, bc);
        @(posedge clk); #1;
        for (int v = 1; v <= 10; v++) exp_q.push_back(W'(v));
        issue(OP_UP, 8'd10);
        repeat (4) begin @(posedge clk); #1; end
        rst = 1'b0;
        #1;
        checks++;
        if (t_out !== '0) begin
            errors++;
            $display("FAIL abort_gate t=%h expected 0", t_out);
        end
        @(posedge clk); #1;
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || cmd_ready !== 1'b1 || remaining !== '0 || q_in !== 4'h4) begin
            errors++;
            $display("FAIL abort_state busy=%b done=%b ready=%b rem=%0d q=%h expected 0 0 1 0 4",
                     busy, done, cmd_ready, remaining, q_in);
        end
        rst = 1'b1;
        exp_q.delete();
        @(posedge clk); #1;
        checks++;
        if (done !== 1'b0 || q_in !== 4'h4) begin
            errors++;
            $display("FAIL abort_no_done done=%b q=%h expected 0 4", done, q_in);
        end
        exp_q.push_back(4'h3); exp_q.push_back(4'h2);
        issue(OP_DOWN, 8'd2);
        wait_done(10, seen, edges, bc);
        checks++;
        if (!seen || edges != 2 || q_in !== 4'h2) begin
            errors++;
            $display("FAIL after_abort seen=%b edges=%0d q=%h expected 1 2 2", seen, edges, q_in);
        end
        @(posedge clk); #1;
    endtask

    initial begin
        test_reset();
        test_clear_count_up();
        test_load();
        test_wrap();
        test_halt();
        test_back_to_back();
        test_abort();
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain left=%0d expected 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
